bus_seq: RTL and testbench
==========================

BUS_SEQ -- requirements
Module: bus_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning data and address width in bits.
REQ-002 The module SHALL have parameter NSRC, default 8, meaning the number of bus sources (1..15).
REQ-003 The module SHALL have parameter MEM_MASK, default 8'b0110_0000, meaning that bit k set marks source k+1 as a memory source needing wait states.
REQ-004 The module SHALL have parameter MEM_WAIT, default 1, meaning wait cycles for memory sources (>=1).
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 src_data  input  NSRC*WIDTH  flattened sources; source k (1-based) occupies bits [k*WIDTH-1:(k-1)*WIDTH].
REQ-008 sel  input  4  source select; 1..NSRC selects that source; 0 or >NSRC selects constant zero.
REQ-009 req  input  1  transfer request, sampled each cycle.
REQ-010 ar  input  WIDTH  address-register value, captured on accept.
REQ-011 data_out  output  WIDTH  registered bus value; holds between transfers.
REQ-012 addr  output  WIDTH  registered address; holds between transfers.
REQ-013 valid  output  1  one-cycle pulse; data_out is new this cycle.
REQ-014 busy  output  1  high while a memory transfer is in progress.

Function
REQ-015 FSM states: IDLE, WAIT; busy SHALL equal (state==WAIT).
REQ-016 A request SHALL be accepted at edge E when req=1 and state=IDLE; req while busy=1 SHALL be ignored, not queued.
REQ-017 On accept, addr SHALL load ar, and sel SHALL be latched internally.
REQ-018 Non-memory accept (sel not marking a MEM_MASK source): data_out SHALL load the selected source (zero if sel invalid) at E; valid=1 the cycle after E; state stays IDLE, so back-to-back requests complete one per cycle.
REQ-019 Memory accept: state SHALL go to WAIT with counter = MEM_WAIT at E; addr is presented during the wait.
REQ-020 In WAIT, counter SHALL decrement each edge; at the edge where counter==1, data_out SHALL load the latched source's current value, state returns to IDLE, valid=1 the following cycle.
REQ-021 Memory latency: request accepted at edge E yields valid in the cycle starting at edge E+MEM_WAIT.
REQ-022 valid SHALL be 0 in every cycle not specified above.
REQ-023 Source inputs changing during WAIT SHALL be reflected only by the final capture value.
REQ-024 The 1-based slot indexing SHALL be computed at WIDTH-independent index arithmetic; no truncation of sel.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, counter=0, data_out=0, addr=0, valid=0, busy=0.
REQ-026 Reset during WAIT SHALL abort the transfer with no valid pulse; first accept possible on first edge after rst_n rises.

Structure
REQ-027 The state encoding (IDLE/WAIT) and the zero-select code SHALL be in shared package bus_pkg.
REQ-028 The wait counter SHALL be sub-module bus_wait_cnt (load, decrement, last flag); the mux and FSM stay in bus_seq.

Verification
REQ-029 Reset: rst_n low with src_data nonzero -> data_out=0, addr=0, valid=0, busy=0.
REQ-030 Non-memory: sel=2, src2=16'hA5A5, ar=16'h0010, req one cycle -> next cycle data_out=16'hA5A5, addr=16'h0010, valid=1, busy=0.
REQ-031 Memory (MEM_WAIT=1): sel=6, src6 changes 16'h1111->16'h2222 on the accept edge, req -> busy=1 one cycle, then valid=1, data_out=16'h2222.
REQ-032 Ignored request: req held high during WAIT with sel=3 -> no extra valid until busy falls; then sel=3 accepted.
REQ-033 Invalid select: sel=0, then sel=9 (NSRC=8) -> data_out=0 with valid=1 each time.
REQ-034 Abort: reset asserted mid-WAIT -> busy=0, no valid pulse, outputs zero.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the bus sequencer: FSM encoding, zero-select code
// and select decoding helpers.
package bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [3:0] SEL_ZERO = 4'd0;

    function automatic logic sel_ok(
        input logic [3:0]  s,
        input int unsigned nsrc
    );
        return (s != SEL_ZERO) && (32'(s) <= nsrc);
    endfunction

    // Bit k of the mask flags source k+1 as a wait-state memory.
    function automatic logic sel_mem(
        input logic [3:0]  s,
        input int unsigned nsrc,
        input logic [31:0] mask
    );
        logic [31:0] m;
        m = mask >> (32'(s) - 32'd1);
        return sel_ok(s, nsrc) && m[0];
    endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// Wait-state down-counter: load, decrement, flag on the final count.
module bus_wait_cnt #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/bus_seq.sv
// Bus sequencer: selects one of NSRC sources onto a registered bus,
// inserting wait states for sources flagged as memories.
module bus_seq #(
    parameter int          WIDTH    = 16,
    parameter int          NSRC     = 8,
    parameter logic [31:0] MEM_MASK = 32'b0110_0000,
    parameter int          MEM_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [3:0]            sel,
    input  logic                  req,
    input  logic [WIDTH-1:0]      ar,
    output logic [WIDTH-1:0]      data_out,
    output logic [WIDTH-1:0]      addr,
    output logic                  valid,
    output logic                  busy
);

    import bus_pkg::*;

    localparam int CNT_W = $clog2(MEM_WAIT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [3:0]       sel_q, sel_d;
    logic             valid_q, valid_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    logic [3:0]       mux_sel;
    logic [WIDTH-1:0] mux_val;

    bus_wait_cnt #(
        .CW(CNT_W)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .load_val_i(CNT_W'(MEM_WAIT)),
        .dec_i     (cnt_dec),
        .cnt_o     (cnt),
        .last_o    (cnt_last)
    );

    // While waiting, the mux follows the latched select, not the live one.
    always_comb begin
        mux_sel = (state_q == WAIT) ? sel_q : sel;
        mux_val = '0;
        for (int k = 1; k <= NSRC; k++) begin
            if (int'(mux_sel) == k) begin
                mux_val = src_data[(k-1)*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        valid_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = ar;
                    sel_d  = sel;
                    if (sel_mem(sel, NSRC, MEM_MASK)) begin
                        state_d  = WAIT;
                        cnt_load = 1'b1;
                    end else begin
                        data_d  = mux_val;
                        valid_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    data_d  = mux_val;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            sel_q   <= SEL_ZERO;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = data_q;
    assign addr     = addr_q;
    assign valid    = valid_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_bus_seq.sv
// Directed bench for bus_seq with a scoreboard of expected
// (data, addr) pairs popped whenever valid is seen.
module tb_bus_seq;

    localparam int W = 16;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] src_data;
    logic [3:0]     sel;
    logic           req;
    logic [W-1:0]   ar;
    logic [W-1:0]   data_out;
    logic [W-1:0]   addr;
    logic           valid;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] sb[$];

    bus_seq #(
        .WIDTH   (W),
        .NSRC    (N),
        .MEM_MASK(32'b0110_0000),
        .MEM_WAIT(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_data(src_data),
        .sel     (sel),
        .req     (req),
        .ar      (ar),
        .data_out(data_out),
        .addr    (addr),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int k, input logic [W-1:0] v);
        src_data[(k-1)*W +: W] = v;
    endtask

    task automatic push(input logic [W-1:0] d, input logic [W-1:0] a);
        sb.push_back({d, a});
    endtask

    // Advance one clock, sample 1ns after the edge, score any valid.
    task automatic cyc();
        logic [2*W-1:0] e;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_data", 32'(data_out), 32'(e[2*W-1:W]));
                chk("sb_addr", 32'(addr), 32'(e[W-1:0]));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        sel   = 4'd0;
        ar    = '0;
        for (int k = 1; k <= N; k++) set_src(k, W'(k * 16'h1111));

        // Reset with nonzero sources
        #3;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_valid", 32'(valid), 32'd0);

        // Non-memory transfer
        set_src(2, 16'hA5A5);
        sel = 4'd2; ar = 16'h0010; req = 1'b1;
        push(16'hA5A5, 16'h0010);
        cyc();
        chk("nm_valid", 32'(valid), 32'd1);
        chk("nm_busy", 32'(busy), 32'd0);
        req = 1'b0;
        cyc();
        chk("nm_pulse", 32'(valid), 32'd0);
        chk("nm_hold", 32'(data_out), 32'hA5A5);

        // Memory transfer, source changes on the accept edge
        set_src(6, 16'h1111);
        sel = 4'd6; ar = 16'h0060; req = 1'b1;
        push(16'h2222, 16'h0060);
        cyc();
        set_src(6, 16'h2222);
        chk("mem_busy", 32'(busy), 32'd1);
        chk("mem_nov", 32'(valid), 32'd0);
        chk("mem_addr", 32'(addr), 32'h0060);
        req = 1'b0;
        cyc();
        chk("mem_valid", 32'(valid), 32'd1);
        chk("mem_done", 32'(busy), 32'd0);
        cyc();
        chk("mem_pulse", 32'(valid), 32'd0);

        // Request during WAIT is ignored, then accepted
        set_src(7, 16'h7777);
        sel = 4'd7; ar = 16'h0070; req = 1'b1;
        push(16'h7777, 16'h0070);
        cyc();
        chk("ign_busy", 32'(busy), 32'd1);
        set_src(3, 16'h3333);
        sel = 4'd3; ar = 16'h0033;
        push(16'h3333, 16'h0033);
        cyc();
        chk("ign_memv", 32'(valid), 32'd1);
        chk("ign_free", 32'(busy), 32'd0);
        cyc();
        chk("ign_acc", 32'(valid), 32'd1);
        req = 1'b0;
        cyc();
        chk("ign_pulse", 32'(valid), 32'd0);

        // Invalid selects, back to back
        sel = 4'd0; ar = 16'h0100; req = 1'b1;
        push(16'h0000, 16'h0100);
        cyc();
        chk("sel0_valid", 32'(valid), 32'd1);
        sel = 4'd9; ar = 16'h0200;
        push(16'h0000, 16'h0200);
        cyc();
        chk("sel9_valid", 32'(valid), 32'd1);
        sel = 4'd15; ar = 16'h0300;
        push(16'h0000, 16'h0300);
        cyc();
        chk("sel15_valid", 32'(valid), 32'd1);
        chk("sel15_busy", 32'(busy), 32'd0);
        req = 1'b0;
        cyc();

        // Source 8 boundary, non-memory
        set_src(8, 16'h8888);
        sel = 4'd8; ar = 16'h0080; req = 1'b1;
        push(16'h8888, 16'h0080);
        cyc();
        chk("s8_valid", 32'(valid), 32'd1);
        req = 1'b0;

        // Abort mid-WAIT
        sel = 4'd7; ar = 16'h0077; req = 1'b1;
        cyc();
        chk("ab_busy", 32'(busy), 32'd1);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ab_busy0", 32'(busy), 32'd0);
        chk("ab_data", 32'(data_out), 32'd0);
        chk("ab_addr", 32'(addr), 32'd0);
        chk("ab_valid", 32'(valid), 32'd0);
        cyc();
        chk("ab_rst_v", 32'(valid), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("ab_post_v", 32'(valid), 32'd0);

        // First accept after reset
        sel = 4'd1; ar = 16'h0001; req = 1'b1;
        push(16'h1111, 16'h0001);
        cyc();
        chk("post_valid", 32'(valid), 32'd1);
        req = 1'b0;
        cyc();
        chk("post_pulse", 32'(valid), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
